// File: rtl/mem_req_rr_scheduler.sv
// Round-robin scheduler sharing one memory command port between NREQ
// requesters, with one outstanding transaction and a response watchdog.
module mem_req_rr_scheduler #(
    parameter int         NREQ          = 3,
    parameter int         TIMEOUT       = 1024,
    parameter logic [1:0] TIMEOUT_ERRTY = 2'd3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*32-1:0]      req_addr,
    input  logic [NREQ-1:0]         req_wen,
    input  logic [NREQ*32-1:0]      req_wdata,
    input  logic [NREQ*2-1:0]       req_wmask,
    input  logic [NREQ*2-1:0]       req_pte,
    output logic [NREQ-1:0]         resp_valid,
    output logic                    resp_error,
    output logic [1:0]              resp_errty,
    output logic [31:0]             resp_rdata,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [31:0]             mem_req_addr,
    output logic                    mem_req_wen,
    output logic [31:0]             mem_req_wdata,
    output logic [1:0]              mem_req_wmask,
    output logic [1:0]              mem_req_pte,
    input  logic                    mem_resp_valid,
    input  logic                    mem_resp_error,
    input  logic [1:0]              mem_resp_errty,
    input  logic [31:0]             mem_resp_rdata,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] owner
);

    localparam int IW = $clog2(NREQ);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TLAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [TW-1:0] TMAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DRAIN
    } state_t;

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   grant;
    logic [IW-1:0]   grant_nxt;
    logic            found;
    logic            accept;
    logic            wd_hit;
    logic [TW-1:0]   timer;
    logic [NREQ-1:0] own_oh;
    int              idx;

    // Search starts at rr_ptr and wraps, so the last winner goes to the back
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req_valid[idx]) begin
                grant = IW'(idx);
                found = 1'b1;
            end
        end
    end

    assign grant_nxt = (grant == IW'(NREQ - 1)) ? '0 : grant + 1'b1;
    assign accept    = (state == IDLE) && found;
    assign req_ready = accept ? (NREQ'(1) << grant) : '0;

    assign busy          = (state != IDLE);
    assign mem_req_valid = (state == ISSUE);
    assign own_oh        = NREQ'(1) << owner;

    // A real response on the expiry cycle takes priority over the watchdog
    assign wd_hit = (TIMEOUT != 0) && (state == WAIT)
                 && !mem_resp_valid && (timer == TLAST);

    assign resp_valid = ((state == WAIT) && (mem_resp_valid || wd_hit))
                      ? own_oh : '0;
    assign resp_error = wd_hit | mem_resp_error;
    assign resp_errty = wd_hit ? TIMEOUT_ERRTY : mem_resp_errty;
    assign resp_rdata = wd_hit ? 32'd0 : mem_resp_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            owner         <= '0;
            timer         <= '0;
            mem_req_addr  <= '0;
            mem_req_wen   <= 1'b0;
            mem_req_wdata <= '0;
            mem_req_wmask <= '0;
            mem_req_pte   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        mem_req_addr  <= req_addr[32*grant +: 32];
                        mem_req_wen   <= req_wen[grant];
                        mem_req_wdata <= req_wdata[32*grant +: 32];
                        mem_req_wmask <= req_wmask[2*grant +: 2];
                        mem_req_pte   <= req_pte[2*grant +: 2];
                        owner         <= grant;
                        rr_ptr        <= grant_nxt;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_req_ready) begin
                        state <= WAIT;
                        timer <= '0;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        state <= IDLE;
                    end else if (wd_hit) begin
                        state <= DRAIN;
                    end else if (timer != TMAX) begin
                        timer <= timer + 1'b1;
                    end
                end
                DRAIN: begin
                    if (mem_resp_valid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_rr_scheduler.sv
// Scoreboard bench for mem_req_rr_scheduler: directed stimulus pushes
// expected commands/responses, a negedge monitor pops and compares.
module tb_mem_req_rr_scheduler;

    localparam int NREQ = 3;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*32-1:0] req_addr;
    logic [NREQ-1:0]   req_wen;
    logic [NREQ*32-1:0] req_wdata;
    logic [NREQ*2-1:0] req_wmask;
    logic [NREQ*2-1:0] req_pte;
    logic [NREQ-1:0]   resp_valid;
    logic              resp_error;
    logic [1:0]        resp_errty;
    logic [31:0]       resp_rdata;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [31:0]       mem_req_addr;
    logic              mem_req_wen;
    logic [31:0]       mem_req_wdata;
    logic [1:0]        mem_req_wmask;
    logic [1:0]        mem_req_pte;
    logic              mem_resp_valid;
    logic              mem_resp_error;
    logic [1:0]        mem_resp_errty;
    logic [31:0]       mem_resp_rdata;
    logic              busy;
    logic [1:0]        owner;

    mem_req_rr_scheduler #(
        .NREQ(NREQ),
        .TIMEOUT(8),
        .TIMEOUT_ERRTY(2'd3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr(req_addr),
        .req_wen(req_wen),
        .req_wdata(req_wdata),
        .req_wmask(req_wmask),
        .req_pte(req_pte),
        .resp_valid(resp_valid),
        .resp_error(resp_error),
        .resp_errty(resp_errty),
        .resp_rdata(resp_rdata),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen),
        .mem_req_wdata(mem_req_wdata),
        .mem_req_wmask(mem_req_wmask),
        .mem_req_pte(mem_req_pte),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_error(mem_resp_error),
        .mem_resp_errty(mem_resp_errty),
        .mem_resp_rdata(mem_resp_rdata),
        .busy(busy),
        .owner(owner)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [1:0]  wmask;
        logic [1:0]  pte;
        logic [1:0]  own;
    } cmd_t;

    typedef struct packed {
        logic [2:0]  vld;
        logic        err;
        logic [1:0]  ety;
        logic [31:0] rdata;
    } rsp_t;

    cmd_t exp_cmd[$];
    rsp_t exp_rsp[$];
    int   total = 0;
    int   passed = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string name, logic [127:0] got, logic [127:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int i, logic [31:0] a, logic w,
                           logic [31:0] d, logic [1:0] m, logic [1:0] p);
        req_addr[32*i +: 32] = a;
        req_wen[i]           = w;
        req_wdata[32*i +: 32] = d;
        req_wmask[2*i +: 2]  = m;
        req_pte[2*i +: 2]    = p;
    endtask

    function automatic cmd_t mk_cmd(int i, logic [31:0] a, logic w,
                                    logic [31:0] d, logic [1:0] m,
                                    logic [1:0] p);
        cmd_t c;
        c.addr  = a;
        c.wen   = w;
        c.wdata = d;
        c.wmask = m;
        c.pte   = p;
        c.own   = 2'(i);
        return c;
    endfunction

    function automatic rsp_t mk_rsp(logic [2:0] v, logic e,
                                    logic [1:0] t, logic [31:0] r);
        rsp_t s;
        s.vld   = v;
        s.err   = e;
        s.ety   = t;
        s.rdata = r;
        return s;
    endfunction

    // Monitor: compare every issued command and every response strobe
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_req_valid && mem_req_ready) begin
                cmd_t g;
                g = cmd_t'({mem_req_addr, mem_req_wen, mem_req_wdata,
                            mem_req_wmask, mem_req_pte, owner});
                if (exp_cmd.size() == 0) chk("cmd_unexpected", g, 0);
                else chk("cmd", g, exp_cmd.pop_front());
            end
            if (resp_valid != '0) begin
                rsp_t r;
                r = rsp_t'({resp_valid, resp_error, resp_errty, resp_rdata});
                if (exp_rsp.size() == 0) chk("rsp_unexpected", r, 0);
                else chk("rsp", r, exp_rsp.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL tb_time_limit: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst_n          = 1'b0;
        req_valid      = '0;
        req_addr       = '0;
        req_wen        = '0;
        req_wdata      = '0;
        req_wmask      = '0;
        req_pte        = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_error = 1'b0;
        mem_resp_errty = 2'd0;
        mem_resp_rdata = '0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_mvalid", mem_req_valid, 0);
        chk("rst_rvalid", resp_valid, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_owner", owner, 0);
        tick();
        tick();
        rst_n = 1'b1;

        // Round robin: all requesters valid, response one cycle after issue
        for (int i = 0; i < NREQ; i++)
            set_req(i, 32'h1000_0000 + 32'(i) * 32'h100, (i == 1),
                    32'hA000_0000 + 32'(i), 2'd2, 2'(i));
        req_valid     = 3'b111;
        mem_req_ready = 1'b1;
        #1;
        for (int n = 0; n < 6; n++) begin
            int g;
            g = n % 3;
            chk("rr_grant", req_ready, 3'(1) << g);
            exp_cmd.push_back(mk_cmd(g, 32'h1000_0000 + 32'(g) * 32'h100,
                                     (g == 1), 32'hA000_0000 + 32'(g),
                                     2'd2, 2'(g)));
            tick();
            if (n == 5) req_valid = '0;
            tick();
            mem_resp_valid = 1'b1;
            mem_resp_rdata = 32'hB000_0000 + 32'(n);
            exp_rsp.push_back(mk_rsp(3'(1) << g, 1'b0, 2'd0,
                                     32'hB000_0000 + 32'(n)));
            tick();
            mem_resp_valid = 1'b0;
        end

        // Single request from requester 0
        set_req(0, 32'h8000_0000, 1'b0, 32'h0, 2'd1, 2'd0);
        req_valid = 3'b001;
        #1;
        chk("single_ready", req_ready, 3'b001);
        exp_cmd.push_back(mk_cmd(0, 32'h8000_0000, 1'b0, 32'h0, 2'd1, 2'd0));
        tick();
        req_valid = '0;
        tick();
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'hDEAD_BEEF;
        exp_rsp.push_back(mk_rsp(3'b001, 1'b0, 2'd0, 32'hDEAD_BEEF));
        tick();
        mem_resp_valid = 1'b0;
        chk("single_busy", busy, 0);

        // Backpressure on requester 1 for five cycles
        mem_req_ready = 1'b0;
        set_req(1, 32'h2222_0000, 1'b1, 32'h5A5A_5A5A, 2'd3, 2'd1);
        req_valid = 3'b010;
        #1;
        chk("bp_ready", req_ready, 3'b010);
        exp_cmd.push_back(mk_cmd(1, 32'h2222_0000, 1'b1, 32'h5A5A_5A5A,
                                 2'd3, 2'd1));
        tick();
        req_valid = 3'b111;
        set_req(1, 32'hDEAD_0000, 1'b0, 32'h0, 2'd0, 2'd0);
        for (int c = 0; c < 5; c++) begin
            chk("bp_hold", {mem_req_valid, mem_req_addr, req_ready},
                {1'b1, 32'h2222_0000, 3'b000});
            tick();
        end
        mem_req_ready = 1'b1;
        req_valid = '0;
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_error = 1'b1;
        mem_resp_errty = 2'd1;
        mem_resp_rdata = 32'h0000_1234;
        exp_rsp.push_back(mk_rsp(3'b010, 1'b1, 2'd1, 32'h0000_1234));
        tick();
        mem_resp_valid = 1'b0;
        mem_resp_error = 1'b0;
        mem_resp_errty = 2'd0;

        // Watchdog on requester 2, then a late response is swallowed
        set_req(2, 32'h3333_0000, 1'b0, 32'h0, 2'd2, 2'd2);
        req_valid = 3'b100;
        exp_cmd.push_back(mk_cmd(2, 32'h3333_0000, 1'b0, 32'h0, 2'd2, 2'd2));
        exp_rsp.push_back(mk_rsp(3'b100, 1'b1, 2'd3, 32'h0));
        mem_resp_rdata = 32'hFFFF_0000;
        tick();
        req_valid = '0;
        tick();
        for (int c = 1; c < 8; c++) begin
            chk("wd_early", resp_valid, 0);
            tick();
        end
        chk("wd_fire", resp_valid, 3'b100);
        tick();
        chk("drain_busy", busy, 1);
        req_valid = 3'b001;
        #1;
        chk("drain_noissue", req_ready, 0);
        tick();
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h7777_7777;
        #1;
        chk("drain_silent", resp_valid, 0);
        req_valid = '0;
        tick();
        mem_resp_valid = 1'b0;
        chk("drain_idle", busy, 0);

        // Response arriving exactly on the watchdog cycle wins
        set_req(0, 32'h4444_0000, 1'b0, 32'h0, 2'd2, 2'd0);
        req_valid = 3'b001;
        exp_cmd.push_back(mk_cmd(0, 32'h4444_0000, 1'b0, 32'h0, 2'd2, 2'd0));
        tick();
        req_valid = '0;
        tick();
        for (int c = 1; c < 8; c++) tick();
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'hCAFE_F00D;
        exp_rsp.push_back(mk_rsp(3'b001, 1'b0, 2'd0, 32'hCAFE_F00D));
        tick();
        mem_resp_valid = 1'b0;
        chk("tie_idle", busy, 0);

        // Asynchronous reset in the middle of WAIT
        set_req(1, 32'h5555_0000, 1'b0, 32'h0, 2'd2, 2'd0);
        req_valid = 3'b010;
        exp_cmd.push_back(mk_cmd(1, 32'h5555_0000, 1'b0, 32'h0, 2'd2, 2'd0));
        tick();
        req_valid = '0;
        tick();
        tick();
        chk("pre_rst_busy", busy, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_mvalid", mem_req_valid, 0);
        chk("arst_owner", owner, 0);
        req_valid = 3'b111;
        #1;
        chk("arst_rrptr", req_ready, 3'b001);
        req_valid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        chk("cmdq_empty", exp_cmd.size(), 0);
        chk("rspq_empty", exp_rsp.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
